// File: rtl/reply_frame_parser_if.sv
// rtl/reply_frame_parser_if.sv - received byte stream in, decoded reply frame out
interface reply_frame_parser_if #(
   parameter int MAXLEN = 8
);
   logic                valid;
   logic [7:0]          din;
   logic [2:0]          st;
   logic                newreply;
   logic                bad_frame;
   logic [7:0]          rtype;
   logic [7:0]          rlen;
   logic [8*MAXLEN-1:0] rdata;

   modport master (
      output valid, din,
      input  st, newreply, bad_frame, rtype, rlen, rdata
   );

   modport slave (
      input  valid, din,
      output st, newreply, bad_frame, rtype, rlen, rdata
   );
endinterface

// File: rtl/reply_frame_parser.sv
// rtl/reply_frame_parser.sv - reply frame decoder: header hunt, length/checksum/type check, inter-byte timeout
module reply_frame_parser #(
   parameter logic [7:0] HEAD0    = 8'hEB,
   parameter logic [7:0] HEAD1    = 8'h90,
   parameter logic [7:0] CODE_OK  = 8'h00,
   parameter logic [7:0] CODE_ERR = 8'h04,
   parameter logic [7:0] CODE_ST  = 8'h05,
   parameter int         MAXLEN   = 8,
   parameter int         TIMEOUT  = 1000
) (
   input logic                 clk,
   input logic                 rst_n,
   reply_frame_parser_if.slave bus
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int DW = 8 * MAXLEN;

   typedef enum logic [2:0] {HUNT0, HUNT1, TYPE, LEN, DATA, CHK} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    type_q, type_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    idx_q, idx_d;
   logic [DW-1:0] buf_q, buf_d;
   logic [2:0]    st_q, st_d;
   logic          newreply_q, newreply_d;
   logic          bad_q, bad_d;
   logic [7:0]    rtype_q, rtype_d;
   logic [7:0]    rlen_q, rlen_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          timeout;
   logic          type_ok;

   // A byte arriving on the expiry cycle beats the timeout because valid gates it.
   always_comb begin
      timeout = 1'b0;
      if (TIMEOUT > 0)
         timeout = (state_q != HUNT0) && !bus.valid && (cnt_q == CW'(TIMEOUT - 1));
   end

   assign type_ok = (type_q == CODE_OK) || (type_q == CODE_ERR) || (type_q == CODE_ST);

   always_comb begin
      state_d    = state_q;
      type_d     = type_q;
      len_d      = len_q;
      sum_d      = sum_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      st_d       = st_q;
      rtype_d    = rtype_q;
      rlen_d     = rlen_q;
      rdata_d    = rdata_q;
      newreply_d = 1'b0;
      bad_d      = 1'b0;

      if (TIMEOUT == 0 || state_q == HUNT0 || bus.valid)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;

      if (timeout) begin
         state_d = HUNT0;
         cnt_d   = '0;
         bad_d   = (state_q != HUNT1);
      end else if (bus.valid) begin
         case (state_q)
            HUNT0: if (bus.din == HEAD0) state_d = HUNT1;
            HUNT1: begin
               if (bus.din == HEAD1)      state_d = TYPE;
               else if (bus.din != HEAD0) state_d = HUNT0;
            end
            TYPE: begin
               type_d  = bus.din;
               sum_d   = bus.din;
               state_d = LEN;
            end
            LEN: begin
               len_d = bus.din;
               sum_d = sum_q + bus.din;
               idx_d = '0;
               buf_d = '0;
               if (bus.din > 8'(MAXLEN)) begin
                  state_d = HUNT0;
                  bad_d   = 1'b1;
               end else if (bus.din == 8'd0) begin
                  state_d = CHK;
               end else begin
                  state_d = DATA;
               end
            end
            DATA: begin
               for (int i = 0; i < MAXLEN; i++)
                  if (idx_q == 8'(i)) buf_d[8*i +: 8] = bus.din;
               sum_d = sum_q + bus.din;
               idx_d = idx_q + 8'd1;
               if (idx_q + 8'd1 == len_q) state_d = CHK;
            end
            CHK: begin
               if (bus.din == sum_q && type_ok) begin
                  case (type_q)
                     CODE_OK:  st_d = 3'b001;
                     CODE_ERR: st_d = 3'b010;
                     default:  st_d = 3'b100;
                  endcase
                  rtype_d    = type_q;
                  rlen_d     = len_q;
                  rdata_d    = buf_q;
                  newreply_d = 1'b1;
               end else begin
                  bad_d = 1'b1;
               end
               state_d = HUNT0;
            end
            default: state_d = HUNT0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT0;
         cnt_q      <= '0;
         type_q     <= '0;
         len_q      <= '0;
         sum_q      <= '0;
         idx_q      <= '0;
         buf_q      <= '0;
         st_q       <= '0;
         newreply_q <= 1'b0;
         bad_q      <= 1'b0;
         rtype_q    <= '0;
         rlen_q     <= '0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         type_q     <= type_d;
         len_q      <= len_d;
         sum_q      <= sum_d;
         idx_q      <= idx_d;
         buf_q      <= buf_d;
         st_q       <= st_d;
         newreply_q <= newreply_d;
         bad_q      <= bad_d;
         rtype_q    <= rtype_d;
         rlen_q     <= rlen_d;
         rdata_q    <= rdata_d;
      end
   end

   assign bus.st        = st_q;
   assign bus.newreply  = newreply_q;
   assign bus.bad_frame = bad_q;
   assign bus.rtype     = rtype_q;
   assign bus.rlen      = rlen_q;
   assign bus.rdata     = rdata_q;
endmodule
